// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - descriptor-in / instruction-out bundle for instr_encoder
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [3:0]  in_alu_op;
  logic [2:0]  in_br_type;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        addr_load;
  logic [31:0] addr_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;

  modport slave (
    input  in_valid, in_kind, in_alu_op, in_br_type, in_rd, in_rs1, in_rs2, in_imm,
    input  addr_load, addr_base, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err
  );

  modport master (
    output in_valid, in_kind, in_alu_op, in_br_type, in_rd, in_rs1, in_rs2, in_imm,
    output addr_load, addr_base, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err
  );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction encoder from descriptors
module instr_encoder (
  input  logic               clk,
  input  logic               rst,
  instr_encoder_if.slave     bus
);

  localparam logic [3:0] K_R = 4'd0, K_IALU = 4'd1, K_LW = 4'd2, K_SW = 4'd3, K_LUI = 4'd4,
                         K_AUIPC = 4'd5, K_BR = 4'd6, K_JAL = 4'd7, K_JALR = 4'd8, K_LI = 4'd9;

  typedef enum logic [1:0] {IDLE, HOLD, LI_HI, LI_LO} state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] lo_q, lo_d;
  logic        err_q, err_d;

  logic [31:0] imm;
  logic [4:0]  rd, rs1, rs2;
  logic        fits12, fits13, fits21;
  logic [2:0]  alu_f3, br_f3;
  logic        alu_alt, alu_ok, br_ok, is_shift;
  logic [11:0] ialu_imm;
  logic [19:0] li_hi;
  logic        enc_legal, enc_two;
  logic [31:0] enc_w0, enc_w1;

  logic out_valid, in_ready, hs, acc;

  assign imm = bus.in_imm;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;

  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    alu_f3  = 3'b000;
    alu_alt = 1'b0;
    alu_ok  = 1'b1;
    case (bus.in_alu_op)
      4'd0: alu_f3 = 3'b000;
      4'd1: begin alu_f3 = 3'b000; alu_alt = 1'b1; end
      4'd2: alu_f3 = 3'b001;
      4'd3: alu_f3 = 3'b010;
      4'd4: alu_f3 = 3'b011;
      4'd5: alu_f3 = 3'b100;
      4'd6: alu_f3 = 3'b101;
      4'd7: begin alu_f3 = 3'b101; alu_alt = 1'b1; end
      4'd8: alu_f3 = 3'b110;
      4'd9: alu_f3 = 3'b111;
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    br_f3 = 3'b000;
    br_ok = 1'b1;
    case (bus.in_br_type)
      3'd0: br_f3 = 3'b000;
      3'd1: br_f3 = 3'b001;
      3'd2: br_f3 = 3'b100;
      3'd3: br_f3 = 3'b101;
      3'd4: br_f3 = 3'b110;
      3'd5: br_f3 = 3'b111;
      default: br_ok = 1'b0;
    endcase
  end

  assign is_shift = (bus.in_alu_op == 4'd2) || (bus.in_alu_op == 4'd6) || (bus.in_alu_op == 4'd7);
  assign ialu_imm = is_shift ? {(alu_alt ? 7'h20 : 7'h00), imm[4:0]} : imm[11:0];
  // Rounds the upper part so the sign-extended ADDI low half lands back on imm.
  assign li_hi    = imm[31:12] + {19'd0, imm[11]};

  always_comb begin
    enc_legal = 1'b1;
    enc_two   = 1'b0;
    enc_w0    = '0;
    enc_w1    = '0;
    case (bus.in_kind)
      K_R: begin
        enc_legal = alu_ok;
        enc_w0    = {(alu_alt ? 7'h20 : 7'h00), rs2, rs1, alu_f3, rd, 7'h33};
      end
      K_IALU: begin
        enc_legal = alu_ok && (bus.in_alu_op != 4'd1) && (is_shift ? ~(|imm[31:5]) : fits12);
        enc_w0    = {ialu_imm, rs1, alu_f3, rd, 7'h13};
      end
      K_LW: begin
        enc_legal = fits12;
        enc_w0    = {imm[11:0], rs1, 3'b010, rd, 7'h03};
      end
      K_SW: begin
        enc_legal = fits12;
        enc_w0    = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
      end
      K_LUI, K_AUIPC: begin
        enc_legal = ~(|imm[11:0]);
        enc_w0    = {imm[31:12], rd, (bus.in_kind == K_LUI) ? 7'h37 : 7'h17};
      end
      K_BR: begin
        enc_legal = br_ok && fits13 && !imm[0];
        enc_w0    = {imm[12], imm[10:5], rs2, rs1, br_f3, imm[4:1], imm[11], 7'h63};
      end
      K_JAL: begin
        enc_legal = fits21 && !imm[0];
        enc_w0    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
      end
      K_JALR: begin
        enc_legal = fits12;
        enc_w0    = {imm[11:0], rs1, 3'b000, rd, 7'h67};
      end
      K_LI: begin
        if (fits12) begin
          enc_w0 = {imm[11:0], 5'd0, 3'b000, rd, 7'h13};
        end else begin
          enc_two = 1'b1;
          enc_w0  = {li_hi, rd, 7'h37};
          enc_w1  = {imm[11:0], rd, 3'b000, rd, 7'h13};
        end
      end
      default: enc_legal = 1'b0;
    endcase
  end

  assign out_valid = (state_q != IDLE);
  assign in_ready  = !bus.addr_load &&
                     ((state_q == IDLE) || (((state_q == HOLD) || (state_q == LI_LO)) && bus.out_ready));
  assign hs        = out_valid && bus.out_ready;
  assign acc       = bus.in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    err_d   = 1'b0;
    if (hs) begin
      addr_d = addr_q + 32'd4;
      if (state_q == LI_HI) begin
        state_d = LI_LO;
        instr_d = lo_q;
      end else begin
        state_d = IDLE;
      end
    end
    if (acc) begin
      if (enc_legal) begin
        instr_d = enc_w0;
        lo_d    = enc_w1;
        state_d = enc_two ? LI_HI : HOLD;
      end else begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end
    if (bus.addr_load && (state_q == IDLE)) begin
      addr_d = bus.addr_base & ~32'h3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      addr_q  <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = instr_q;
  assign bus.out_addr  = addr_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed and randomized bench for instr_encoder
module tb_instr_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  instr_encoder_if bus ();
  instr_encoder dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ity(input logic [31:0] i12, input logic [31:0] r1,
                                      input logic [31:0] f3, input logic [31:0] d,
                                      input logic [31:0] opc);
    return (i12 << 20) | (r1 << 15) | (f3 << 12) | (d << 7) | opc;
  endfunction

  // Reference: number of emitted words (0 = illegal) and the words themselves.
  function automatic void ref_enc(input int k, input int op, input int br,
                                  input logic [31:0] rd, input logic [31:0] rs1,
                                  input logic [31:0] rs2, input logic [31:0] imm,
                                  output int n, output logic [31:0] w0, output logic [31:0] w1);
    int s;
    int alu_f3 [10];
    int br_f3 [6];
    logic [31:0] f3, f7, i12;
    bit s12;
    alu_f3 = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    br_f3  = '{0, 1, 4, 5, 6, 7};
    s   = $signed(imm);
    s12 = (s >= -2048) && (s <= 2047);
    n = 0; w0 = '0; w1 = '0; f3 = '0; f7 = '0; i12 = '0;
    case (k)
      0: if (op < 10) begin
        f3 = 32'(alu_f3[op]);
        f7 = (op == 1 || op == 7) ? 32'h20 : 32'h0;
        w0 = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
        n = 1;
      end
      1: if (op < 10 && op != 1) begin
        f3 = 32'(alu_f3[op]);
        if (op == 2 || op == 6 || op == 7) begin
          if (imm <= 32'd31) begin
            i12 = ((op == 7) ? 32'h400 : 32'h0) | imm;
            n = 1;
          end
        end else if (s12) begin
          i12 = imm & 32'hFFF;
          n = 1;
        end
        w0 = ity(i12, rs1, f3, rd, 32'h13);
      end
      2: if (s12) begin n = 1; w0 = ity(imm & 32'hFFF, rs1, 32'd2, rd, 32'h03); end
      3: if (s12) begin
        n = 1;
        w0 = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (32'd2 << 12) |
             ((imm & 32'h1F) << 7) | 32'h23;
      end
      4, 5: if ((imm % 4096) == 0) begin
        n = 1;
        w0 = imm | (rd << 7) | ((k == 4) ? 32'h37 : 32'h17);
      end
      6: if (br < 6 && s >= -4096 && s <= 4095 && (s % 2) == 0) begin
        n = 1;
        f3 = 32'(br_f3[br]);
        w0 = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20) |
             (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
      end
      7: if (s >= -(1 << 20) && s < (1 << 20) && (s % 2) == 0) begin
        n = 1;
        w0 = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 1) << 20) |
             (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
      end
      8: if (s12) begin n = 1; w0 = ity(imm & 32'hFFF, rs1, 32'd0, rd, 32'h67); end
      9: if (s12) begin
        n = 1;
        w0 = ity(imm & 32'hFFF, 32'd0, 32'd0, rd, 32'h13);
      end else begin
        n = 2;
        w0 = ((imm + 32'h800) & 32'hFFFFF000) | (rd << 7) | 32'h37;
        w1 = ity(imm & 32'hFFF, rd, 32'd0, rd, 32'h13);
      end
      default: n = 0;
    endcase
  endfunction

  task automatic set_desc(input int k, input int op, input int br, input int rd,
                          input int rs1, input int rs2, input logic [31:0] imm);
    bus.in_kind    = 4'(k);
    bus.in_alu_op  = 4'(op);
    bus.in_br_type = 3'(br);
    bus.in_rd      = 5'(rd);
    bus.in_rs1     = 5'(rs1);
    bus.in_rs2     = 5'(rs2);
    bus.in_imm     = imm;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.addr_load = 1'b0; bus.out_ready = 1'b0; bus.addr_base = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] exp_q [$];
  logic [31:0] m_addr;
  logic [31:0] w0, w1;
  bit          exp_err, acc, hs, was_empty;
  int          n;

  initial begin
    set_desc(0, 0, 0, 0, 0, 0, '0);
    do_reset();
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_out_addr", bus.out_addr, 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);

    // R add, then hold for 3 cycles under backpressure
    set_desc(0, 0, 0, 3, 1, 2, '0);
    bus.in_valid = 1'b1;
    #1 check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk); bus.in_valid = 1'b0;
    #1 check("radd_valid", 32'(bus.out_valid), 32'd1);
    check("radd_instr", bus.out_instr, 32'h002081B3);
    check("radd_addr", bus.out_addr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_instr", bus.out_instr, 32'h002081B3);
      check("hold_addr", bus.out_addr, 32'h0);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(negedge clk); bus.out_ready = 1'b0;
    #1 check("release_valid", 32'(bus.out_valid), 32'd0);
    check("release_addr", bus.out_addr, 32'h4);

    // LI with split LUI/ADDI
    do_reset();
    set_desc(9, 0, 0, 5, 0, 0, 32'h12345FFF);
    bus.in_valid = 1'b1;
    @(negedge clk); bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #1 check("li_lui", bus.out_instr, 32'h123462B7);
    check("li_lui_addr", bus.out_addr, 32'h0);
    check("li_hi_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    #1 check("li_addi", bus.out_instr, 32'hFFF28293);
    check("li_addi_addr", bus.out_addr, 32'h4);
    @(negedge clk);
    #1 check("li_done_valid", 32'(bus.out_valid), 32'd0);
    check("li_done_addr", bus.out_addr, 32'h8);

    // BEQ backward branch
    do_reset();
    set_desc(6, 0, 0, 0, 1, 2, 32'hFFFFFFFC);
    bus.in_valid = 1'b1;
    @(negedge clk); bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #1 check("beq_instr", bus.out_instr, 32'hFE208EE3);

    // Two illegal descriptors back to back
    do_reset();
    bus.out_ready = 1'b1;
    set_desc(1, 1, 0, 1, 1, 0, 32'd5);
    bus.in_valid = 1'b1;
    @(negedge clk);
    #1 check("ill1_err", 32'(bus.err), 32'd1);
    check("ill1_valid", 32'(bus.out_valid), 32'd0);
    set_desc(1, 2, 0, 1, 1, 0, 32'd32);
    @(negedge clk); bus.in_valid = 1'b0;
    #1 check("ill2_err", 32'(bus.err), 32'd1);
    check("ill2_valid", 32'(bus.out_valid), 32'd0);
    check("ill2_addr", bus.out_addr, 32'h0);
    @(negedge clk);
    #1 check("ill_err_clear", 32'(bus.err), 32'd0);

    // Reset while the ADDI half of LI is held
    do_reset();
    set_desc(9, 0, 0, 5, 0, 0, 32'h12345FFF);
    bus.in_valid = 1'b1;
    @(negedge clk); bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk); rst = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
    #1 check("rstli_valid", 32'(bus.out_valid), 32'd0);
    check("rstli_addr", bus.out_addr, 32'h0);
    check("rstli_in_ready", 32'(bus.in_ready), 32'd1);

    // Randomized stream against the reference model
    do_reset();
    m_addr  = '0;
    exp_err = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      check("rnd_err", 32'(bus.err), 32'(exp_err));
      bus.in_valid = ($urandom_range(0, 3) != 0);
      set_desc(($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9),
               ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9),
               $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31), '0);
      case ($urandom_range(0, 4))
        0: bus.in_imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        1: bus.in_imm = $urandom;
        2: bus.in_imm = $urandom & 32'hFFFFF000;
        3: bus.in_imm = 32'($urandom_range(0, 40));
        default: bus.in_imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'h1;
      endcase
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.addr_load = ($urandom_range(0, 19) == 0);
      bus.addr_base = $urandom;
      #1;
      check("rnd_in_ready", 32'(bus.in_ready),
            32'(!bus.addr_load && (exp_q.size() == 0 || (exp_q.size() == 1 && bus.out_ready))));
      check("rnd_out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
      if (bus.out_valid && exp_q.size() > 0) begin
        check("rnd_instr", bus.out_instr, exp_q[0]);
        check("rnd_addr", bus.out_addr, m_addr);
      end
      acc = bus.in_valid && bus.in_ready;
      hs  = bus.out_valid && bus.out_ready;
      @(posedge clk);
      was_empty = (exp_q.size() == 0);
      if (hs && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        m_addr = m_addr + 32'd4;
      end
      exp_err = 1'b0;
      if (acc) begin
        ref_enc(int'(bus.in_kind), int'(bus.in_alu_op), int'(bus.in_br_type),
                32'(bus.in_rd), 32'(bus.in_rs1), 32'(bus.in_rs2), bus.in_imm, n, w0, w1);
        if (n == 0) exp_err = 1'b1;
        if (n >= 1) exp_q.push_back(w0);
        if (n == 2) exp_q.push_back(w1);
      end
      if (bus.addr_load && was_empty) m_addr = bus.addr_base & ~32'h3;
    end

    // Drain
    @(negedge clk);
    bus.in_valid = 1'b0; bus.addr_load = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      #1;
      check("drain_instr", bus.out_instr, exp_q[0]);
      check("drain_addr", bus.out_addr, m_addr);
      void'(exp_q.pop_front());
      m_addr = m_addr + 32'd4;
      @(negedge clk);
    end
    #1 check("drain_empty", 32'(bus.out_valid), 32'd0);
    check("drain_final_addr", bus.out_addr, m_addr);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
